scarv_cop_dispatch: RTL and testbench

SCARV_COP_DISPATCH -- requirements
Module: scarv_cop_dispatch

---
 rtl/scarv_cop_common.sv | 36 +++
 rtl/scarv_cop_dispatch_timer.sv | 28 ++
 rtl/scarv_cop_dispatch.sv | 125 ++++++++++++
 tb/tb_scarv_cop_dispatch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_common.sv
// Shared definitions for the SCARV coprocessor dispatch logic.
//   disp_state_t : dispatcher FSM state encoding
//   CLS_*        : decoder class codes; each code is the fu_valid bit index
//   cop_rsp_t    : response held towards the CPU while the instruction retires
//   class_onehot : class code -> functional-unit start vector
package scarv_cop_common;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } disp_state_t;

  localparam logic [2:0] CLS_PACKED_ARITH = 3'd0;
  localparam logic [2:0] CLS_TWIDDLE      = 3'd1;
  localparam logic [2:0] CLS_LOADSTORE    = 3'd2;
  localparam logic [2:0] CLS_RANDOM       = 3'd3;
  localparam logic [2:0] CLS_MOVE         = 3'd4;
  localparam logic [2:0] CLS_MP           = 3'd5;
  localparam logic [2:0] CLS_BITWISE      = 3'd6;
  // No unit answers to code 7, so it is handled like an illegal instruction.
  localparam logic [2:0] CLS_INVALID      = 3'd7;

  typedef struct packed {
    logic        wen;
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } cop_rsp_t;

  function automatic logic [7:0] class_onehot(input logic [2:0] cls);
    return 8'b1 << cls;
  endfunction

endpackage

// File: rtl/scarv_cop_dispatch_timer.sv
// EXEC-phase watchdog for the functional units.
//   g_clk, g_resetn : clock, async active-low reset
//   clear           : zero the count (held while not executing)
//   enable          : count one cycle
//   expired         : count has reached LIMIT; the count holds there
module scarv_cop_dispatch_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [W-1:0] count;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)              count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expired) count <= count + W'(1);
  end

  assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/scarv_cop_dispatch.sv
// SCARV coprocessor instruction dispatcher: accepts one instruction from the
// CPU, samples the decoder, starts the selected functional unit and returns a
// single response. Only one instruction is ever in flight.
//   cpu_insn_req/ack/enc, cpu_rs1 : instruction hand-off from the CPU
//   cpu_insn_rsp/rsp_ack          : response hand-shake back to the CPU
//   cpu_wen/rd/wdata/exc          : response payload (wen/exc only in RESP)
//   id_encoded -> id_exception/class/rd : decoder round trip
//   fu_valid/fu_rs1 -> fu_done/gpr_wen/gpr_wdata/exception : unit interface
module scarv_cop_dispatch
  import scarv_cop_common::*;
#(
  parameter int unsigned FU_TIMEOUT = 255
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic        cpu_insn_rsp,
  input  logic        cpu_rsp_ack,
  output logic        cpu_wen,
  output logic [4:0]  cpu_rd,
  output logic [31:0] cpu_wdata,
  output logic        cpu_exc,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [2:0]  id_class,
  input  logic [4:0]  id_rd,
  output logic [7:0]  fu_valid,
  output logic [31:0] fu_rs1,
  input  logic        fu_done,
  input  logic        fu_gpr_wen,
  input  logic [31:0] fu_gpr_wdata,
  input  logic        fu_exception
);

  disp_state_t state, state_nxt;
  logic [2:0]  cls_q;
  cop_rsp_t    rsp_q;
  logic        dec_exc;
  logic        tmr_expired;

  assign dec_exc = id_exception | (id_class == CLS_INVALID);

  // Counter sits at zero outside EXEC, so it is already clear on entry.
  scarv_cop_dispatch_timer #(.LIMIT(FU_TIMEOUT)) u_timer (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .clear   (state != ST_EXEC),
    .enable  (state == ST_EXEC),
    .expired (tmr_expired)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cpu_insn_ack = 1'b0;
    cpu_insn_rsp = 1'b0;
    cpu_wen      = 1'b0;
    cpu_exc      = 1'b0;
    fu_valid     = 8'h00;
    case (state)
      ST_IDLE: begin
        cpu_insn_ack = 1'b1;
        if (cpu_insn_req) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = dec_exc ? ST_RESP : ST_EXEC;
      ST_EXEC: begin
        fu_valid = class_onehot(cls_q);
        if (fu_done || tmr_expired) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        cpu_insn_rsp = 1'b1;
        cpu_wen      = rsp_q.wen;
        cpu_exc      = rsp_q.exc;
        if (cpu_rsp_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      id_encoded <= '0;
      fu_rs1     <= '0;
      cls_q      <= '0;
      rsp_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cpu_insn_req) begin
          id_encoded <= cpu_insn_enc;
          fu_rs1     <= cpu_rs1;
        end
        ST_DECODE: begin
          cls_q       <= id_class;
          rsp_q.rd    <= id_rd;
          rsp_q.exc   <= dec_exc;
          rsp_q.wen   <= 1'b0;
          rsp_q.wdata <= '0;
        end
        ST_EXEC: begin
          // A unit finishing on the timeout cycle still counts as done.
          if (fu_done) begin
            rsp_q.wen   <= fu_gpr_wen & ~fu_exception;
            rsp_q.wdata <= fu_gpr_wdata;
            rsp_q.exc   <= fu_exception;
          end else if (tmr_expired) begin
            rsp_q.wen <= 1'b0;
            rsp_q.exc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rd    = rsp_q.rd;
  assign cpu_wdata = rsp_q.wdata;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Directed bench for scarv_cop_dispatch with a response scoreboard.
module tb_scarv_cop_dispatch;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        cpu_insn_req = 1'b0;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc = '0;
  logic [31:0] cpu_rs1 = '0;
  logic        cpu_insn_rsp;
  logic        cpu_rsp_ack = 1'b0;
  logic        cpu_wen;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_wdata;
  logic        cpu_exc;
  logic [31:0] id_encoded;
  logic        id_exception = 1'b0;
  logic [2:0]  id_class = '0;
  logic [4:0]  id_rd = '0;
  logic [7:0]  fu_valid;
  logic [31:0] fu_rs1;
  logic        fu_done = 1'b0;
  logic        fu_gpr_wen = 1'b0;
  logic [31:0] fu_gpr_wdata = '0;
  logic        fu_exception = 1'b0;

  scarv_cop_dispatch #(.FU_TIMEOUT(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cpu_insn_rsp(cpu_insn_rsp), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_wen(cpu_wen), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata), .cpu_exc(cpu_exc),
    .id_encoded(id_encoded), .id_exception(id_exception),
    .id_class(id_class), .id_rd(id_rd),
    .fu_valid(fu_valid), .fu_rs1(fu_rs1), .fu_done(fu_done),
    .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata),
    .fu_exception(fu_exception)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic        wen;
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Pops the oldest expected response and compares the payload on the bus.
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed response expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " rsp"}, 32'(cpu_insn_rsp), 32'd1);
      chk({tag, " wen"}, 32'(cpu_wen), 32'(e.wen));
      chk({tag, " exc"}, 32'(cpu_exc), 32'(e.exc));
      chk({tag, " rd"},  32'(cpu_rd),  32'(e.rd));
      if (e.wen) chk({tag, " wdata"}, cpu_wdata, e.wdata);
    end
  endtask

  // Steps until a response appears or the budget runs out.
  task automatic wait_rsp(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (!cpu_insn_rsp && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (!cpu_insn_rsp) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed no response expected one within %0d cycles", tag, max_cyc);
    end
  endtask

  task automatic ack_rsp();
    cpu_rsp_ack = 1'b1;
    step();
    cpu_rsp_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int cyc;

    // Reset state
    #2;
    chk("rst ack",   32'(cpu_insn_ack), 32'd1);
    chk("rst rsp",   32'(cpu_insn_rsp), 32'd0);
    chk("rst wen",   32'(cpu_wen),      32'd0);
    chk("rst exc",   32'(cpu_exc),      32'd0);
    chk("rst rd",    32'(cpu_rd),       32'd0);
    chk("rst wdata", cpu_wdata,         32'd0);
    chk("rst fuv",   32'(fu_valid),     32'd0);
    chk("rst enc",   id_encoded,        32'd0);
    chk("rst rs1",   fu_rs1,            32'd0);
    step();
    g_resetn = 1'b1;
    step();

    // Move class, unit done on the first EXEC cycle
    chk("s1 ack idle", 32'(cpu_insn_ack), 32'd1);
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h12345678; cpu_rs1 = 32'hDEADBEEF;
    id_class = 3'd4; id_rd = 5'd5; id_exception = 1'b0;
    sb.push_back('{1'b1, 1'b0, 5'd5, 32'hCAFEF00D});
    step();  // cycle 1: DECODE
    cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_rs1 = '0;
    chk("s1 enc",      id_encoded, 32'h12345678);
    chk("s1 rs1",      fu_rs1,     32'hDEADBEEF);
    chk("s1 ack busy", 32'(cpu_insn_ack), 32'd0);
    chk("s1 fuv dec",  32'(fu_valid), 32'd0);
    fu_done = 1'b1; fu_gpr_wen = 1'b1; fu_gpr_wdata = 32'hCAFEF00D;
    step();  // cycle 2: EXEC
    id_class = 3'd1; id_rd = 5'd9;
    chk("s1 fuv exec", 32'(fu_valid), 32'h10);
    chk("s1 rsp exec", 32'(cpu_insn_rsp), 32'd0);
    chk("s1 wen exec", 32'(cpu_wen), 32'd0);
    step();  // cycle 3: RESP
    fu_done = 1'b0; fu_gpr_wen = 1'b0; fu_gpr_wdata = '0;
    check_rsp("s1");
    chk("s1 fuv resp", 32'(fu_valid), 32'd0);
    chk("s1 rs1 hold", fu_rs1, 32'hDEADBEEF);
    ack_rsp();
    chk("s1 ack back", 32'(cpu_insn_ack), 32'd1);
    chk("s1 rsp drop", 32'(cpu_insn_rsp), 32'd0);
    chk("s1 wen drop", 32'(cpu_wen), 32'd0);

    // Decoder exception: response at cycle 2, no unit started
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h00000BAD; id_exception = 1'b1;
    id_class = 3'd4; id_rd = 5'd7;
    sb.push_back('{1'b0, 1'b1, 5'd7, 32'd0});
    step();
    cpu_insn_req = 1'b0;
    chk("s2 fuv dec", 32'(fu_valid), 32'd0);
    step();
    id_exception = 1'b0;
    chk("s2 fuv resp", 32'(fu_valid), 32'd0);
    check_rsp("s2");
    ack_rsp();

    // Class 7 behaves as an exception
    cpu_insn_req = 1'b1; id_class = 3'd7; id_rd = 5'd2;
    sb.push_back('{1'b0, 1'b1, 5'd2, 32'd0});
    step();
    cpu_insn_req = 1'b0;
    step();
    chk("s3 fuv", 32'(fu_valid), 32'd0);
    check_rsp("s3");
    ack_rsp();

    // Timeout: FU_TIMEOUT=4 keeps the unit started for 5 cycles
    cpu_insn_req = 1'b1; id_class = 3'd2; id_rd = 5'd4;
    sb.push_back('{1'b0, 1'b1, 5'd4, 32'd0});
    step();
    cpu_insn_req = 1'b0;
    nv = 0;
    for (int i = 0; i < 20 && !cpu_insn_rsp; i++) begin
      step();
      if (fu_valid != 8'h00) begin
        nv++;
        chk("s4 fuv", 32'(fu_valid), 32'h04);
      end
    end
    chk("s4 fuv cycles", 32'(nv), 32'd5);
    chk("s4 fuv drop", 32'(fu_valid), 32'd0);
    check_rsp("s4");
    ack_rsp();

    // fu_done on the timeout cycle wins
    cpu_insn_req = 1'b1; id_class = 3'd6; id_rd = 5'd11;
    sb.push_back('{1'b1, 1'b0, 5'd11, 32'h0BADCAFE});
    step();  // DECODE
    cpu_insn_req = 1'b0;
    step();  // EXEC, count 0
    for (int i = 0; i < 4; i++) step();
    chk("s5 fuv last", 32'(fu_valid), 32'h40);
    fu_done = 1'b1; fu_gpr_wen = 1'b1; fu_gpr_wdata = 32'h0BADCAFE;
    step();
    fu_done = 1'b0; fu_gpr_wen = 1'b0;
    check_rsp("s5");
    ack_rsp();

    // Unit exception masks the GPR write
    cpu_insn_req = 1'b1; id_class = 3'd0; id_rd = 5'd1;
    sb.push_back('{1'b0, 1'b1, 5'd1, 32'd0});
    step();
    cpu_insn_req = 1'b0;
    fu_done = 1'b1; fu_gpr_wen = 1'b1; fu_exception = 1'b1; fu_gpr_wdata = 32'h77777777;
    step();
    chk("s6 fuv", 32'(fu_valid), 32'h01);
    step();
    fu_done = 1'b0; fu_gpr_wen = 1'b0; fu_exception = 1'b0;
    check_rsp("s6");
    ack_rsp();

    // Response back-pressure with a second request waiting
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h11110000; id_class = 3'd1; id_rd = 5'd12;
    sb.push_back('{1'b1, 1'b0, 5'd12, 32'h5A5A5A5A});
    step();
    cpu_insn_req = 1'b0;
    fu_done = 1'b1; fu_gpr_wen = 1'b1; fu_gpr_wdata = 32'h5A5A5A5A;
    step();
    step();
    fu_done = 1'b0; fu_gpr_wen = 1'b0; fu_gpr_wdata = '0;
    check_rsp("s7");
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'hFEEDFACE; id_exception = 1'b1; id_rd = 5'd3;
    sb.push_back('{1'b0, 1'b1, 5'd3, 32'd0});
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s7 hold rsp",   32'(cpu_insn_rsp), 32'd1);
      chk("s7 hold ack",   32'(cpu_insn_ack), 32'd0);
      chk("s7 hold wen",   32'(cpu_wen),      32'd1);
      chk("s7 hold rd",    32'(cpu_rd),       32'd12);
      chk("s7 hold wdata", cpu_wdata,         32'h5A5A5A5A);
      chk("s7 hold exc",   32'(cpu_exc),      32'd0);
      chk("s7 hold enc",   id_encoded,        32'h11110000);
    end
    ack_rsp();
    chk("s7 idle ack", 32'(cpu_insn_ack), 32'd1);
    chk("s7 idle enc", id_encoded, 32'h11110000);
    step();
    cpu_insn_req = 1'b0;
    chk("s7 2nd enc", id_encoded, 32'hFEEDFACE);
    chk("s7 2nd ack", 32'(cpu_insn_ack), 32'd0);
    step();
    id_exception = 1'b0;
    check_rsp("s7b");
    ack_rsp();

    // Reset pulsed during EXEC abandons the instruction
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h33333333; id_class = 3'd3; id_rd = 5'd8;
    step();
    cpu_insn_req = 1'b0;
    step();
    chk("s8 fuv exec", 32'(fu_valid), 32'h08);
    g_resetn = 1'b0;
    #1;
    chk("s8 fuv rst", 32'(fu_valid), 32'd0);
    chk("s8 rsp rst", 32'(cpu_insn_rsp), 32'd0);
    step();
    g_resetn = 1'b1;
    #1;
    chk("s8 ack rel", 32'(cpu_insn_ack), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("s8 no rsp", 32'(cpu_insn_rsp), 32'd0);
      chk("s8 no fuv", 32'(fu_valid), 32'd0);
    end

    // Normal instruction after reset, latency measured
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h44444444; id_class = 3'd5; id_rd = 5'd31;
    sb.push_back('{1'b1, 1'b0, 5'd31, 32'hFFFFFFFF});
    step();  // cycle 1
    cpu_insn_req = 1'b0;
    fu_done = 1'b1; fu_gpr_wen = 1'b1; fu_gpr_wdata = 32'hFFFFFFFF;
    wait_rsp("s9", 10, cyc);
    fu_done = 1'b0; fu_gpr_wen = 1'b0;
    chk("s9 latency", 32'(cyc + 1), 32'd3);
    check_rsp("s9");
    ack_rsp();

    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
